alu_op_producer: RTL and testbench

- Synthesizable, parametrised successor to the testbench operation producer. Emits a configurable-length stream of TinyALU operations (A, B, op) over a valid/ready handshake.
- Three generation modes: directed, incrementing and LFSR-random.
- Sits in the FPGA-resident stimulus path and feeds the ALU driver or an operation FIFO. Software or the host link configures it and pulses start.

---
 rtl/tinyalu_pkg.sv | 37 +++
 rtl/alu_op_producer_if.sv | 29 ++
 rtl/alu_lfsr32.sv | 25 ++
 rtl/alu_op_producer.sv | 173 +++++++++++++++++
 tb/tb_alu_op_producer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared TinyALU types and constants for the operation producer
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4
    } operation_t;

    typedef enum logic [1:0] {
        MODE_DIRECTED = 2'd0,
        MODE_INCR     = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_RSVD     = 2'd3
    } prod_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } prod_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Directed mode walks add, and, xor, mul and wraps back to add.
    function automatic operation_t directed_op(input logic [1:0] idx);
        case (idx)
            2'd0:    return add_op;
            2'd1:    return and_op;
            2'd2:    return xor_op;
            default: return mul_op;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_producer_if.sv
// rtl/alu_op_producer_if.sv - valid/ready operation stream between producer and consumer
interface alu_op_producer_if #(
    parameter int DATA_W = 8
);
    import tinyalu_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    operation_t        op_code;

    modport master (
        output op_valid,
        output op_a,
        output op_b,
        output op_code,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_a,
        input  op_b,
        input  op_code,
        output op_ready
    );

endinterface

// File: rtl/alu_lfsr32.sv
// rtl/alu_lfsr32.sv - 32-bit Galois LFSR, advances on enable, reloads seed on reset
module alu_lfsr32 #(
    parameter logic [31:0] SEED = 32'h1234_5678,
    parameter logic [31:0] TAPS = 32'h8020_0003
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] state
);

    logic [31:0] r_state;

    // Shift right; when the bit falling out is 1, fold the tap mask back in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (en) begin
            r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? TAPS : 32'h0);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/alu_op_producer.sv
// rtl/alu_op_producer.sv - configurable-length TinyALU operation stream generator
module alu_op_producer
    import tinyalu_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'h1234_5678
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_count,
    input  logic [DATA_W-1:0]   cfg_a,
    input  logic [DATA_W-1:0]   cfg_b,
    input  logic [2:0]          cfg_op,
    alu_op_producer_if.master   op_if,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    issued
);

    prod_state_t       r_state;
    prod_state_t       w_state_next;
    prod_mode_t        r_mode;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_issued;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    operation_t        r_op;
    logic [1:0]        r_dir_idx;

    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;
    operation_t        w_op_next;
    logic [1:0]        w_dir_idx_next;
    logic [31:0]       w_lfsr;
    logic              w_unused_lfsr;

    logic       w_start_go;
    logic       w_fire;
    logic       w_last;
    logic       w_load_first;
    logic       w_load_next;
    logic       w_load;
    prod_mode_t w_mode;

    assign w_start_go   = (r_state == ST_IDLE) && start;
    assign w_fire       = (r_state == ST_GEN) && op_if.op_ready;
    assign w_last       = w_fire && ((r_issued + CNT_W'(1)) == r_count);
    assign w_load_first = w_start_go && (cfg_count != '0);
    // An aborting handshake still counts, but nothing further is staged.
    assign w_load_next  = w_fire && !w_last && !abort;
    assign w_load       = w_load_first || w_load_next;
    assign w_mode       = w_start_go ? prod_mode_t'(cfg_mode) : r_mode;

    alu_lfsr32 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_load && (w_mode == MODE_RANDOM)),
        .state (w_lfsr)
    );

    // Only some LFSR bits feed the operands; the rest are intentionally dropped.
    assign w_unused_lfsr = ^w_lfsr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over completion in GEN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (cfg_count == '0) ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Next-item mux: first item comes from cfg_*, later items from the held item.
    always_comb begin
        w_a_next       = r_a;
        w_b_next       = r_b;
        w_op_next      = r_op;
        w_dir_idx_next = r_dir_idx;
        case (w_mode)
            MODE_RANDOM: begin
                w_a_next  = w_lfsr[DATA_W-1:0];
                w_b_next  = w_lfsr[DATA_W+15:16];
                w_op_next = operation_t'({1'b0, w_lfsr[31:30]} + 3'd1);
            end
            MODE_INCR: begin
                if (w_start_go) begin
                    w_a_next  = cfg_a;
                    w_b_next  = cfg_b;
                    w_op_next = operation_t'(cfg_op);
                end else begin
                    w_a_next  = r_a + DATA_W'(1);
                    w_b_next  = r_b - DATA_W'(1);
                end
            end
            default: begin
                if (w_start_go) begin
                    w_a_next       = cfg_a;
                    w_b_next       = cfg_b;
                    w_op_next      = add_op;
                    w_dir_idx_next = 2'd1;
                end else begin
                    w_op_next      = directed_op(r_dir_idx);
                    w_dir_idx_next = r_dir_idx + 2'd1;
                end
            end
        endcase
    end

    // Run configuration, issued counter and the presented operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= MODE_DIRECTED;
            r_count   <= '0;
            r_issued  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= no_op;
            r_dir_idx <= 2'd0;
        end else begin
            if (w_start_go) begin
                r_mode   <= prod_mode_t'(cfg_mode);
                r_count  <= cfg_count;
                r_issued <= '0;
            end
            if (w_fire) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_load) begin
                r_a       <= w_a_next;
                r_b       <= w_b_next;
                r_op      <= w_op_next;
                r_dir_idx <= w_dir_idx_next;
            end
        end
    end

    assign op_if.op_valid = (r_state == ST_GEN);
    assign op_if.op_a     = r_a;
    assign op_if.op_b     = r_b;
    assign op_if.op_code  = r_op;
    assign busy           = (r_state == ST_GEN);
    assign done           = (r_state == ST_DONE);
    assign issued         = r_issued;

endmodule

// File: tb/tb_alu_op_producer.sv
// tb/tb_alu_op_producer.sv - randomized self-checking bench for alu_op_producer
module tb_alu_op_producer;
    import tinyalu_pkg::*;

    localparam int          DATA_W = 8;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] SEED   = 32'h1234_5678;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_count;
    logic [DATA_W-1:0] cfg_a;
    logic [DATA_W-1:0] cfg_b;
    logic [2:0]        cfg_op;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  issued;

    alu_op_producer_if #(.DATA_W(DATA_W)) op_if ();

    alu_op_producer #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_op    (cfg_op),
        .op_if     (op_if),
        .busy      (busy),
        .done      (done),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] m_lfsr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference: the n items a run will stage, straight from the mode rules.
    task automatic build(input int mode, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input int n);
        for (int i = 0; i < n; i++) begin
            item_t it;
            case (mode)
                1: begin
                    it.a  = 8'(a + i);
                    it.b  = 8'(b - i);
                    it.op = op;
                end
                2: begin
                    it.a   = m_lfsr[7:0];
                    it.b   = m_lfsr[23:16];
                    it.op  = 3'(m_lfsr[31:30] + 1);
                    m_lfsr = lfsr_step(m_lfsr);
                end
                default: begin
                    it.a  = a;
                    it.b  = b;
                    it.op = 3'(1 + (i % 4));
                end
            endcase
            exp_q.push_back(it);
        end
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low for 5 cycles then high.
    task automatic run(input string name, input int mode, input int count,
                       input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input int rmode, input int abort_after);
        int    cyc;
        int    acc;
        int    dones;
        int    first_beat;
        int    last_beat;
        logic  stall;
        bit    fin;
        item_t held;
        item_t got;

        exp_q.delete();
        build(mode, a, b, op, (abort_after > 0) ? abort_after + 1 : count);
        cfg_mode  = mode[1:0];
        cfg_count = CNT_W'(count);
        cfg_a     = a;
        cfg_b     = b;
        cfg_op    = op;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_mode  = 2'($urandom);
        cfg_count = CNT_W'($urandom);
        cfg_a     = 8'($urandom);
        cfg_b     = 8'($urandom);
        cfg_op    = 3'($urandom);
        check({name, ".latency"}, op_if.op_valid, (count != 0));
        if (count == 0) check({name, ".done_at_1"}, done, 1);

        cyc = 0; acc = 0; dones = 0; stall = 0; fin = 0; first_beat = -1; last_beat = -1;
        held = '{8'h0, 8'h0, 3'h0};
        while (!fin && cyc < 3000) begin
            if (abort_after > 0 && acc == abort_after) begin
                op_if.op_ready = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({name, ".abort_valid"}, op_if.op_valid, 0);
                check({name, ".abort_busy"}, busy, 0);
                check({name, ".abort_done"}, done, 0);
                check({name, ".abort_issued"}, issued, abort_after);
                @(negedge clk);
                check({name, ".abort_done2"}, done, 0);
                exp_q.delete();
                fin = 1;
            end else begin
                case (rmode)
                    0:       op_if.op_ready = 1'b1;
                    1:       op_if.op_ready = 1'($urandom_range(0, 1));
                    default: op_if.op_ready = (cyc >= 5);
                endcase
                if (stall && op_if.op_valid)
                    check({name, ".stable"}, {op_if.op_a, op_if.op_b, op_if.op_code},
                          {held.a, held.b, held.op});
                if (op_if.op_valid && op_if.op_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, ".extra_beat"}, 1, 0);
                    end else begin
                        got = exp_q.pop_front();
                        check({name, ".beat"}, {op_if.op_a, op_if.op_b, op_if.op_code},
                              {got.a, got.b, got.op});
                    end
                    acc++;
                    if (first_beat < 0) first_beat = cyc;
                    last_beat = cyc;
                end
                stall = op_if.op_valid && !op_if.op_ready;
                held  = '{op_if.op_a, op_if.op_b, op_if.op_code};
                if (done) begin
                    dones++;
                    fin = 1;
                end
                cyc++;
                @(negedge clk);
            end
        end
        if (!fin) check({name, ".timeout"}, 0, 1);
        if (abort_after == 0) begin
            check({name, ".done_width"}, done, 0);
            check({name, ".done_count"}, dones, 1);
            check({name, ".beats"}, acc, count);
            check({name, ".issued"}, issued, count);
            check({name, ".leftover"}, exp_q.size(), 0);
            if (rmode == 0 && count > 0)
                check({name, ".b2b"}, last_beat - first_beat, count - 1);
        end
        op_if.op_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        cfg_mode       = 2'd0;
        cfg_count      = '0;
        cfg_a          = '0;
        cfg_b          = '0;
        cfg_op         = 3'd0;
        op_if.op_ready = 1'b0;
        m_lfsr         = SEED;

        repeat (2) @(negedge clk);
        check("rst.valid", op_if.op_valid, 0);
        check("rst.abop", {op_if.op_a, op_if.op_b, op_if.op_code}, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.issued", issued, 0);
        reset = 1'b0;
        @(negedge clk);

        run("directed", 0, 4, 8'hFF, 8'h55, 3'd0, 0, 0);
        run("incr_wrap", 1, 3, 8'hFE, 8'h01, 3'd1, 0, 0);
        run("backpressure", 0, 2, 8'hAA, 8'hEE, 3'd0, 2, 0);
        run("zero_count", 0, 0, 8'h12, 8'h34, 3'd0, 1, 0);
        run("incr_noop", 1, 4, 8'h10, 8'h00, 3'd0, 1, 0);
        run("rand_abort", 2, 100, 8'h00, 8'h00, 3'd0, 1, 10);
        run("rand_cont", 2, 5, 8'h00, 8'h00, 3'd0, 1, 0);

        for (int r = 0; r < 8; r++) begin
            run("rand_cfg", int'($urandom_range(0, 3)), int'($urandom_range(1, 20)),
                8'($urandom), 8'($urandom), 3'($urandom), 1, 0);
        end

        // Reset in the middle of a run must clear every output without a clock edge.
        cfg_mode  = 2'd0;
        cfg_count = CNT_W'(50);
        cfg_a     = 8'h5A;
        cfg_b     = 8'hA5;
        start     = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        op_if.op_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst.valid", op_if.op_valid, 0);
        check("midrst.abop", {op_if.op_a, op_if.op_b, op_if.op_code}, 0);
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.issued", issued, 0);
        op_if.op_ready = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_lfsr = SEED;
        @(negedge clk);
        run("rand_after_reset", 2, 3, 8'h00, 8'h00, 3'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
